// File: rtl/sp_mem_scheduler.sv
// sp_mem_scheduler: round-robin sharing of one single-port synchronous memory among load and store ports
// Ports: ld_valid/ld_addr/ld_ready  load address request and grant per port
//        ldr_valid/ldr_data/ldr_ready  registered load result slot per port
//        st_valid/st_addr/st_data/st_ready  store request and grant per port
//        mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side (read data one cycle after read)
//        st_count  stores issued since reset; idle  nothing requested, in flight or held
module sp_mem_scheduler #(
    parameter int LOAD_COUNT  = 2,
    parameter int STORE_COUNT = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LOAD_COUNT-1:0]            ld_valid,
    input  logic [LOAD_COUNT*ADDR_WIDTH-1:0] ld_addr,
    output logic [LOAD_COUNT-1:0]            ld_ready,
    output logic [LOAD_COUNT-1:0]            ldr_valid,
    output logic [LOAD_COUNT*DATA_WIDTH-1:0] ldr_data,
    input  logic [LOAD_COUNT-1:0]            ldr_ready,
    input  logic [STORE_COUNT-1:0]           st_valid,
    input  logic [STORE_COUNT*ADDR_WIDTH-1:0] st_addr,
    input  logic [STORE_COUNT*DATA_WIDTH-1:0] st_data,
    output logic [STORE_COUNT-1:0]           st_ready,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [31:0]                      st_count,
    output logic                             idle
);
    localparam int N  = LOAD_COUNT + STORE_COUNT;
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {EMPTY, INFLIGHT, FULL} slot_t;

    slot_t                            slot_q [LOAD_COUNT];
    slot_t                            slot_d [LOAD_COUNT];
    logic [PW-1:0]                    ptr_q, ptr_d;
    logic [31:0]                      st_count_q, st_count_d;
    logic [LOAD_COUNT*DATA_WIDTH-1:0] ldr_data_q, ldr_data_d;
    logic [N-1:0]                     elig;
    logic [PW-1:0]                    cand, gnt_idx;
    logic                             found, gnt;

    // a held result may be replaced in the same cycle its consumer takes it
    always_comb begin
        elig = '0;
        for (int i = 0; i < LOAD_COUNT; i++)
            elig[i] = ld_valid[i] && (slot_q[i] == EMPTY || (slot_q[i] == FULL && ldr_ready[i]));
        for (int j = 0; j < STORE_COUNT; j++)
            elig[LOAD_COUNT+j] = st_valid[j];
    end

    // scan from the requester after the last winner, wrapping
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!found && elig[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = found && !rst;
    end

    always_comb begin
        ld_ready  = '0;
        st_ready  = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < LOAD_COUNT; i++)
            if (gnt && gnt_idx == PW'(i)) begin
                ld_ready[i] = 1'b1;
                mem_addr    = ld_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        for (int j = 0; j < STORE_COUNT; j++)
            if (gnt && gnt_idx == PW'(LOAD_COUNT + j)) begin
                st_ready[j] = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = st_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata   = st_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    assign mem_en = gnt;

    always_comb begin
        ptr_d      = gnt ? gnt_idx : ptr_q;
        st_count_d = st_count_q + 32'(mem_we);
        ldr_data_d = ldr_data_q;
        for (int i = 0; i < LOAD_COUNT; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i] == INFLIGHT) begin
                slot_d[i] = FULL;
                ldr_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
            end else if (ld_ready[i])
                slot_d[i] = INFLIGHT;
            else if (slot_q[i] == FULL && ldr_ready[i])
                slot_d[i] = EMPTY;
        end
    end

    always_comb begin
        idle = !(|ld_valid) && !(|st_valid);
        for (int i = 0; i < LOAD_COUNT; i++) begin
            ldr_valid[i] = slot_q[i] == FULL;
            idle         = idle && slot_q[i] == EMPTY;
        end
    end

    assign ldr_data = ldr_data_q;
    assign st_count = st_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= PW'(N - 1);
            st_count_q <= '0;
            ldr_data_q <= '0;
            for (int i = 0; i < LOAD_COUNT; i++)
                slot_q[i] <= EMPTY;
        end else begin
            ptr_q      <= ptr_d;
            st_count_q <= st_count_d;
            ldr_data_q <= ldr_data_d;
            slot_q     <= slot_d;
        end
    end
endmodule

// File: tb/tb_sp_mem_scheduler.sv
// tb_sp_mem_scheduler: directed and random checks of sp_mem_scheduler against a behavioural model
module tb_sp_mem_scheduler;
    localparam int LC = 2;
    localparam int SC = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = LC + SC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LC-1:0]     ld_valid = '0;
    logic [LC*AW-1:0]  ld_addr = '0;
    logic [LC-1:0]     ld_ready;
    logic [LC-1:0]     ldr_valid;
    logic [LC*DW-1:0]  ldr_data;
    logic [LC-1:0]     ldr_ready = '0;
    logic [SC-1:0]     st_valid = '0;
    logic [SC*AW-1:0]  st_addr = '0;
    logic [SC*DW-1:0]  st_data = '0;
    logic [SC-1:0]     st_ready;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic [31:0]       st_count;
    logic              idle;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] bram [256] = '{default: '0};
    logic [DW-1:0] ref_mem [256] = '{default: '0};

    int          last;
    bit          pend [LC];
    bit          held [LC];
    logic [DW-1:0] pend_d [LC];
    logic [DW-1:0] hold_d [LC];
    logic [31:0] cnt;

    sp_mem_scheduler #(.LOAD_COUNT(LC), .STORE_COUNT(SC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .ldr_valid(ldr_valid), .ldr_data(ldr_data), .ldr_ready(ldr_ready),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .st_count(st_count), .idle(idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) bram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr[7:0]];
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last = N - 1;
        cnt  = '0;
        for (int i = 0; i < LC; i++) begin
            pend[i] = 0; held[i] = 0; pend_d[i] = '0; hold_d[i] = '0;
        end
    endtask

    // expected outputs for this cycle from the model, then advance the model past the edge
    task automatic model_step();
        bit            el [N];
        int            g;
        logic [LC-1:0] e_ld, e_lv;
        logic [SC-1:0] e_st;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [LC*DW-1:0] e_data;
        logic          e_we, e_idle;
        for (int i = 0; i < LC; i++) el[i] = ld_valid[i] && !pend[i] && (!held[i] || ldr_ready[i]);
        for (int j = 0; j < SC; j++) el[LC+j] = st_valid[j];
        g = -1;
        for (int d = 1; d <= N; d++) if (g < 0 && el[(last + d) % N]) g = (last + d) % N;
        e_ld = '0; e_st = '0; e_addr = '0; e_wd = '0; e_we = 0;
        if (g >= 0 && g < LC) begin
            e_ld[g] = 1'b1;
            e_addr  = ld_addr[g*AW +: AW];
        end else if (g >= LC) begin
            e_st[g-LC] = 1'b1;
            e_we   = 1'b1;
            e_addr = st_addr[(g-LC)*AW +: AW];
            e_wd   = st_data[(g-LC)*DW +: DW];
        end
        e_idle = (ld_valid == '0) && (st_valid == '0);
        for (int i = 0; i < LC; i++) begin
            e_lv[i] = held[i];
            e_data[i*DW +: DW] = hold_d[i];
            if (pend[i] || held[i]) e_idle = 0;
        end
        chk("ld_ready", ld_ready, e_ld);
        chk("st_ready", st_ready, e_st);
        chk("mem_en", mem_en, g >= 0);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("ldr_valid", ldr_valid, e_lv);
        chk("ldr_data", ldr_data, e_data);
        chk("idle", idle, e_idle);
        chk("st_count", st_count, cnt);
        for (int i = 0; i < LC; i++) begin
            if (pend[i]) begin
                held[i] = 1; hold_d[i] = pend_d[i]; pend[i] = 0;
            end else if (held[i] && ldr_ready[i])
                held[i] = 0;
            if (g == i) begin
                pend[i] = 1;
                pend_d[i] = ref_mem[ld_addr[i*AW +: 8]];
            end
        end
        if (g >= LC) begin
            ref_mem[e_addr[7:0]] = e_wd;
            cnt++;
        end
        if (g >= 0) last = g;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ld_valid = '0; st_valid = '0; ldr_ready = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        // requests present during reset must not be granted
        ld_valid = '1; st_valid = '1; ldr_ready = '1;
        ld_addr = {32'h44, 32'h33}; st_addr = {32'h22, 32'h11}; st_data = {32'h99, 32'h88};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_st_ready", st_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ldr_valid", ldr_valid, 0);
        ld_valid = '0; st_valid = '0; ldr_ready = '0;
        rst = 1'b0;
        #1;
        chk("reset_idle", idle, 1);
        chk("reset_ldr_data", ldr_data, 0);
        chk("reset_st_count", st_count, 0);

        // preload 0xAB at 0x10 through store port 1 (only requester, ptr starts at N-1)
        st_valid = 2'b10; st_addr = {32'h10, 32'h0}; st_data = {32'hAB, 32'h0};
        #1;
        chk("preload_st_ready", st_ready, 2'b10);
        chk("preload_we", mem_we, 1);
        tick();
        st_valid = '0;

        // single load, result two cycles after the address handshake
        ld_valid = 2'b01; ld_addr = {32'h0, 32'h10};
        #1;
        chk("single_ld_ready", ld_ready, 2'b01);
        chk("single_mem_addr", mem_addr, 32'h10);
        chk("single_mem_we", mem_we, 0);
        tick();
        ld_valid = '0;
        #1;
        chk("single_t1_valid", ldr_valid, 2'b00);
        tick();
        chk("single_t2_valid", ldr_valid, 2'b01);
        chk("single_t2_data", ldr_data[31:0], 32'hAB);
        ldr_ready = '1;
        tick();

        // store then load of the same address
        st_valid = 2'b01; st_addr = {32'h0, 32'h20}; st_data = {32'h0, 32'h55};
        #1;
        chk("st_ld_we", mem_we, 1);
        chk("st_ld_addr", mem_addr, 32'h20);
        chk("st_ld_wdata", mem_wdata, 32'h55);
        tick();
        st_valid = '0; ld_valid = 2'b10; ld_addr = {32'h20, 32'h0};
        tick();
        ld_valid = '0;
        tick();
        chk("st_ld_valid", ldr_valid[1], 1);
        chk("st_ld_data", ldr_data[63:32], 32'h55);
        tick();

        // all requesters continuously valid: grants rotate 0,1,2,3 from reset
        do_reset();
        ld_valid = '1; st_valid = '1; ldr_ready = '1;
        ld_addr = {32'h5, 32'h4}; st_addr = {32'h7, 32'h6}; st_data = {32'h77, 32'h66};
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rotate", {st_ready, ld_ready}, 4'b0001 << (k % 4));
            tick();
        end
        chk("rotate_st_count", st_count, 4);

        // backpressure on port 1: once its slot is held it is never regranted
        ldr_ready = 2'b01;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k >= 4) begin
                chk("bp_no_grant1", ld_ready[1], 0);
                chk("bp_held1", ldr_valid[1], 1);
            end
            tick();
        end
        ld_valid = 2'b10; st_valid = '0; ldr_ready = '1;
        #1;
        chk("bp_regrant", ld_ready, 2'b10);
        tick();
        ld_valid = '0;
        repeat (3) tick();

        // reset while a load is in flight
        ld_valid = 2'b01; ld_addr = {32'h0, 32'h20};
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ld_ready", ld_ready, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_ldr_valid", ldr_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ld_valid = '0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_no_valid", ldr_valid, 0);
        end
        chk("mid_rst_idle", idle, 1);

        // st_count wraps from all-ones to zero
        force dut.st_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.st_count_q;
        cnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", st_count, 32'hFFFF_FFFF);
        st_valid = 2'b01; st_addr = {32'h0, 32'h3}; st_data = {32'h0, 32'h1234};
        tick();
        chk("wrap_post", st_count, 0);
        st_valid = '0;

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            ld_valid  = LC'($urandom);
            st_valid  = ($urandom_range(0, 3) == 0) ? SC'($urandom) : '0;
            ldr_ready = LC'($urandom);
            for (int i = 0; i < LC; i++) ld_addr[i*AW +: AW] = $urandom_range(0, 63);
            for (int j = 0; j < SC; j++) begin
                st_addr[j*AW +: AW] = $urandom_range(0, 63);
                st_data[j*DW +: DW] = $urandom;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sp_mem_scheduler.md
# sp_mem_scheduler

Shares one single-port synchronous memory (1-cycle read latency) among LOAD_COUNT load ports and STORE_COUNT store ports using round-robin fairness. It sits between the circuit's load/store access ports and a BRAM-style memory, in place of separate fixed-priority read/write arbiters. It returns each load's data through a per-port registered result slot with valid/ready handshake. It also reports a store-issue count and an idle flag for memory-completion logic.

## Interface
Parameters:
- LOAD_COUNT, 2, number of load ports (≥1)
- STORE_COUNT, 2, number of store ports (≥1)
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ld_valid  in  LOAD_COUNT  load address request valid per port
- ld_addr  in  LOAD_COUNT*ADDR_WIDTH  load addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- ld_ready  out  LOAD_COUNT  load address accepted (grant)
- ldr_valid  out  LOAD_COUNT  load result valid per port
- ldr_data  out  LOAD_COUNT*DATA_WIDTH  load results, same packing
- ldr_ready  in  LOAD_COUNT  consumer accepts result
- st_valid  in  STORE_COUNT  store request valid (address and data joined upstream)
- st_addr  in  STORE_COUNT*ADDR_WIDTH  store addresses
- st_data  in  STORE_COUNT*DATA_WIDTH  store data
- st_ready  out  STORE_COUNT  store accepted (grant)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read
- st_count  out  32  stores issued since reset, wraps modulo 2^32
- idle  out  1  no request pending, no load in flight or held

## Operation
- Requester index space N = LOAD_COUNT+STORE_COUNT: loads 0..LOAD_COUNT-1, then stores.
- Per load port slot state: EMPTY, INFLIGHT, FULL. Reset: all EMPTY.
- Load i eligible: ld_valid[i] & (slot EMPTY | (slot FULL & ldr_ready[i])). Store j eligible: st_valid[j].
- At most one grant per cycle: first eligible index scanning from ptr+1 upward, wrapping modulo N. ptr (register) updates to granted index; unchanged if no grant. Reset ptr = N-1, so index 0 has first priority.
- Grant load i: ld_ready[i]=1, mem_en=1, mem_we=0, mem_addr=ld_addr[i]; slot → INFLIGHT.
- INFLIGHT → FULL next cycle; ldr_data[i] <= mem_rdata at that edge.
- FULL: ldr_valid[i]=1; ldr_data stable until handshake. FULL & ldr_ready[i] & no regrant → EMPTY; with regrant → INFLIGHT.
- Grant store j: st_ready[j]=1, mem_en=1, mem_we=1, mem_addr/mem_wdata from port j; st_count += 1.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- ld_ready, st_ready, mem_* are combinational from inputs and state; all forced 0 while rst=1.
- idle = no ld_valid, no st_valid, every slot EMPTY.

## Timing
- Reset values: ld_ready=0, st_ready=0, ldr_valid=0, ldr_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, st_count=0, idle=1 (with inputs idle).
- Load latency: address handshake in cycle t → ldr_valid[i]=1 from cycle t+2.
- Store latency: write issued in grant cycle.
- Per-port load throughput: one every 2 cycles if ldr_ready held high.
- Reset mid-operation: in-flight read dropped, held results discarded, ptr=N-1, st_count=0.
- st_count 0xFFFFFFFF + store → 0x00000000.
- Only one memory access per cycle; loads and stores never both granted.

## Test plan
- Single load: port 0 addr 0x10, memory holds 0xAB at 0x10 → ld_ready[0] cycle t, ldr_valid[0] at t+2 with ldr_data=0xAB.
- All 4 requesters valid continuously, ldr_ready=1 → grants rotate 0,1,2,3,0,… with ptr from reset; each store port gets every 4th cycle; st_count counts 2 per 4 cycles.
- Backpressure: ldr_ready[1]=0 with slot 1 FULL → load 1 never granted, others rotate; ldr_data[1] stable; releasing ldr_ready[1] → regrant same cycle.
- Store then load same address 0x20, data 0x55 → mem_we=1 then read returns 0x55.
- Assert rst while load 0 INFLIGHT → ldr_valid[0] never rises, all outputs 0, idle=1 after reset.
- Preload st_count via 2^32-1 stores (or forced) → next store wraps to 0.
